// File: rtl/uart_pkg.sv
// Shared definitions for the uart block: RX state encoding, oversampling
// constants and the register map used by the bus interface.
package uart_pkg;

    // Receive FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_e;

    // Ticks per bit period, and the tick count at the middle of the start bit.
    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = OVERSAMPLE / 2 - 1;

    // Register addresses.
    localparam logic [1:0] ADDR_TX       = 2'd0;
    localparam logic [1:0] ADDR_RX       = 2'd1;
    localparam logic [1:0] ADDR_FREQ_DIV = 2'd2;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator shared by the TX and RX paths. The tick
// period is freq_divider+1 clk cycles; a divider of 0 ticks every clk.
// A divider change applies against the current count with no resync.
module uart_baud_tick (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] freq_divider,
    output logic       tick
);

    logic [7:0] count;

    assign tick = (count == freq_divider);

    // Free-running counter that wraps to 0 on the tick cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 8'd0;
        end else if (tick) begin
            count <= 8'd0;
        end else begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receive path: 8N1 frames, 16x oversampling, mid-bit sampling.
// Good bytes leave through a one-cycle push strobe; framing and overrun
// errors are one-cycle pulses aligned with where push would have been.
//
// Handshake: push is a one-cycle valid strobe with no ready; the FIFO's
// fifo_full flag, sampled on the stop-sample tick, decides between push
// and overrun, and a byte is never held waiting for space.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = uart_pkg::OVERSAMPLE,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_bit,
    input  logic [7:0]           freq_divider,
    input  logic                 fifo_full,
    output logic                 push,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 frame_error,
    output logic                 overrun,
    output logic                 busy,
    output rx_state_e            rx_state
);

    localparam int CNT_W   = $clog2(OVERSAMPLE);
    localparam int IDX_W   = $clog2(DATA_BITS);
    localparam int MID_PT  = OVERSAMPLE / 2 - 1;
    localparam int LAST_PT = OVERSAMPLE - 1;

    logic                   tick;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    rx_state_e              state, state_n;
    logic [CNT_W-1:0]       sample_cnt, sample_cnt_n;
    logic [IDX_W-1:0]       bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0]   shift_reg, shift_reg_n;
    logic [DATA_BITS-1:0]   data_n;
    logic                   push_n, frame_error_n, overrun_n;

    uart_baud_tick u_baud_tick (
        .clk          (clk),
        .reset        (reset),
        .freq_divider (freq_divider),
        .tick         (tick)
    );

    // Metastability synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_bit};
        end
    end

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign busy     = (state != IDLE);
    assign rx_state = state;

    // State, counters, shift register and registered output pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sample_cnt  <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            data_out    <= '0;
            push        <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_n;
            sample_cnt  <= sample_cnt_n;
            bit_idx     <= bit_idx_n;
            shift_reg   <= shift_reg_n;
            data_out    <= data_n;
            push        <= push_n;
            frame_error <= frame_error_n;
            overrun     <= overrun_n;
        end
    end

    // Next-state logic; every decision is taken on a tick using rx_s.
    always_comb begin
        state_n       = state;
        sample_cnt_n  = sample_cnt;
        bit_idx_n     = bit_idx;
        shift_reg_n   = shift_reg;
        data_n        = data_out;
        push_n        = 1'b0;
        frame_error_n = 1'b0;
        overrun_n     = 1'b0;

        if (tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_n      = START;
                        sample_cnt_n = '0;
                    end
                end

                START: begin
                    if (sample_cnt == CNT_W'(MID_PT)) begin
                        sample_cnt_n = '0;
                        if (!rx_s) begin
                            state_n   = DATA;
                            bit_idx_n = '0;
                        end else begin
                            // Start bit did not last to its midpoint: glitch.
                            state_n = IDLE;
                        end
                    end else begin
                        sample_cnt_n = sample_cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (sample_cnt == CNT_W'(LAST_PT)) begin
                        shift_reg_n  = {rx_s, shift_reg[DATA_BITS-1:1]};
                        sample_cnt_n = '0;
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            state_n = STOP;
                        end else begin
                            bit_idx_n = bit_idx + IDX_W'(1);
                        end
                    end else begin
                        sample_cnt_n = sample_cnt + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (sample_cnt == CNT_W'(LAST_PT)) begin
                        sample_cnt_n = '0;
                        if (rx_s) begin
                            state_n = IDLE;
                            if (!fifo_full) begin
                                data_n = shift_reg;
                                push_n = 1'b1;
                            end else begin
                                overrun_n = 1'b1;
                            end
                        end else begin
                            frame_error_n = 1'b1;
                            state_n       = WAIT_IDLE;
                        end
                    end else begin
                        sample_cnt_n = sample_cnt + CNT_W'(1);
                    end
                end

                WAIT_IDLE: begin
                    // Break or stuck-low line: no new frame until it idles high.
                    if (rx_s) begin
                        state_n = IDLE;
                    end
                end

                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios followed by random
// frames, with a frame-level reference model feeding an expected queue.
module tb_uart_rx;
    import uart_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic       rx_bit;
    logic [7:0] freq_divider;
    logic       fifo_full;
    logic       push;
    logic [7:0] data_out;
    logic       frame_error;
    logic       overrun;
    logic       busy;
    rx_state_e  rx_state;

    always #5 clk = ~clk;

    uart_rx dut (
        .clk          (clk),
        .reset        (reset),
        .rx_bit       (rx_bit),
        .freq_divider (freq_divider),
        .fifo_full    (fifo_full),
        .push         (push),
        .data_out     (data_out),
        .frame_error  (frame_error),
        .overrun      (overrun),
        .busy         (busy),
        .rx_state     (rx_state)
    );

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_push   = 0;
    int         n_ferr   = 0;
    int         n_ovr    = 0;
    int         exp_push = 0;
    int         exp_ferr = 0;
    int         exp_ovr  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_byte = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Monitor: every push must match the head of the expected queue.
    always @(negedge clk) begin
        if (push) begin
            n_push++;
            if (exp_q.size() == 0) begin
                check("push_unexpected", 32'd1, 32'd0);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("data_out", {24'd0, data_out}, {24'd0, e});
            end
        end
        if (frame_error) n_ferr++;
        if (overrun)     n_ovr++;
    end

    // ---------------- driver tasks ----------------
    function automatic int bit_clks();
        return 16 * (int'(freq_divider) + 1);
    endfunction

    task automatic hold(input logic v, input int n);
        rx_bit = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame-level reference model plus line driver. The line is left at the
    // stop-bit level when the task returns.
    task automatic send_frame(input logic [7:0] b, input logic stop_val);
        int bc;
        bc = bit_clks();
        if (!stop_val) begin
            exp_ferr++;
        end else if (fifo_full) begin
            exp_ovr++;
        end else begin
            exp_q.push_back(b);
            exp_push++;
            last_byte = b;
        end
        hold(1'b0, bc);
        for (int i = 0; i < 8; i++) hold(b[i], bc);
        hold(stop_val, bc);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_push"}, n_push, exp_push);
        check({tag, "_ferr"}, n_ferr, exp_ferr);
        check({tag, "_ovr"},  n_ovr,  exp_ovr);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int bc;
        logic [7:0] b;
        logic       bad;

        reset        = 1'b1;
        rx_bit       = 1'b1;
        fifo_full    = 1'b0;
        freq_divider = 8'd6;
        repeat (3) @(posedge clk);
        #1;
        check("rst_push",     {31'd0, push},        32'd0);
        check("rst_ferr",     {31'd0, frame_error}, 32'd0);
        check("rst_ovr",      {31'd0, overrun},     32'd0);
        check("rst_busy",     {31'd0, busy},        32'd0);
        check("rst_data_out", {24'd0, data_out},    32'd0);
        check("rst_state",    {29'd0, rx_state},    {29'd0, IDLE});
        reset = 1'b0;
        hold(1'b1, 50);
        bc = bit_clks();

        // Single frame at 112 clk/bit.
        send_frame(8'h41, 1'b1);
        hold(1'b1, 2 * bc);
        check_counts("single");
        check("single_data", {24'd0, data_out}, 32'h41);
        check("single_busy", {31'd0, busy}, 32'd0);

        // Back-to-back frames, no idle gap.
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        hold(1'b1, 2 * bc);
        check_counts("b2b");

        // Short low glitch on the line.
        hold(1'b0, 21);
        check("glitch_busy_hi", {31'd0, busy}, 32'd1);
        hold(1'b1, 56);
        check("glitch_busy_lo", {31'd0, busy}, 32'd0);
        check("glitch_state", {29'd0, rx_state}, {29'd0, IDLE});
        check_counts("glitch");

        // Framing error with the line held low, then recovery.
        send_frame(8'h3C, 1'b0);
        hold(1'b0, 2 * bc);
        check("ferr_wait_state", {29'd0, rx_state}, {29'd0, WAIT_IDLE});
        check_counts("ferr");
        hold(1'b1, bc);
        check("ferr_idle_state", {29'd0, rx_state}, {29'd0, IDLE});
        send_frame(8'h7E, 1'b1);
        hold(1'b1, 2 * bc);
        check_counts("after_ferr");
        check("after_ferr_data", {24'd0, data_out}, 32'h7E);

        // Overrun: byte dropped while the FIFO is full.
        fifo_full = 1'b1;
        send_frame(8'hC3, 1'b1);
        fifo_full = 1'b0;
        hold(1'b1, bc);
        check_counts("ovr");
        check("ovr_data_hold", {24'd0, data_out}, {24'd0, last_byte});
        send_frame(8'h12, 1'b1);
        hold(1'b1, 2 * bc);
        check_counts("after_ovr");
        check("after_ovr_data", {24'd0, data_out}, 32'h12);

        // Reset in the middle of bit 4 of 0xF0.
        b = 8'hF0;
        hold(1'b0, bc);
        for (int i = 0; i < 4; i++) hold(b[i], bc);
        hold(1'b1, bc / 2);
        reset = 1'b1;
        rx_bit = 1'b1;
        freq_divider = 8'd2;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_data", {24'd0, data_out}, 32'd0);
        check("midrst_state", {29'd0, rx_state}, {29'd0, IDLE});
        reset = 1'b0;
        last_byte = 8'h00;
        bc = bit_clks();
        hold(1'b1, 2 * bc);
        check_counts("midrst");
        send_frame(8'h81, 1'b1);
        hold(1'b1, 2 * bc);
        check_counts("after_rst");
        check("after_rst_data", {24'd0, data_out}, 32'h81);

        // Random frames: random data, divider, FIFO-full and stop errors.
        for (int n = 0; n < 24; n++) begin
            if (n % 6 == 0) begin
                freq_divider = 8'($urandom_range(0, 3));
                hold(1'b1, 300);
            end
            bc        = bit_clks();
            b         = 8'($urandom);
            bad       = ($urandom_range(0, 7) == 0);
            fifo_full = ($urandom_range(0, 3) == 0);
            send_frame(b, !bad);
            fifo_full = 1'b0;
            if (bad) begin
                hold(1'b0, bc);
                hold(1'b1, bc * (1 + int'($urandom_range(0, 1))));
            end else begin
                hold(1'b1, bc * int'($urandom_range(0, 2)));
            end
        end
        hold(1'b1, 3 * bit_clks());
        check_counts("random");
        check("exp_q_empty", exp_q.size(), 32'd0);
        check("final_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
